// File: rtl/butterfly_pkg.sv
// Shared definitions for the 2x2 butterfly router stage.
//
// Holds the default address, level and flit widths, the flit field offsets,
// the output port encoding, and small helpers. The helpers extract the dest
// and src fields of a flit and do a saturating increment for the statistics
// counters.
//
// Flit layout: dest at [DEST_LSB +: ADDR_W], src at [SRC_LSB +: ADDR_W], with
// payload above that.
package butterfly_pkg;

  localparam int ADDR_W   = 3;
  localparam int LVL_W    = 2;
  localparam int FLIT_W   = 64;
  localparam int DEST_LSB = 0;
  localparam int SRC_LSB  = ADDR_W;
  localparam int STAT_W   = 16;

  typedef enum logic {
    PORT_UP   = 1'b0,
    PORT_DOWN = 1'b1
  } port_e;

  function automatic logic [ADDR_W-1:0] get_dest(input logic [FLIT_W-1:0] flit);
    return flit[DEST_LSB +: ADDR_W];
  endfunction

  function automatic logic [ADDR_W-1:0] get_src(input logic [FLIT_W-1:0] flit);
    return flit[SRC_LSB +: ADDR_W];
  endfunction

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] value);
    return (value == '1) ? value : value + 1'b1;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter with a registered priority pointer.
//
// Ports:
//   clk      in   clock
//   rst      in   synchronous reset, active-low (pointer returns to 0)
//   req      in   [1:0] request per input
//   en       in   grant enable (downstream ready); no grant while low
//   gnt      out  [1:0] one-hot grant, combinational
//   gnt_vld  out  a grant is issued this cycle
//   gnt_idx  out  index of the granted input (valid with gnt_vld)
//
// When both inputs request, the input named by the pointer wins. After any
// grant the pointer moves to the other input, so a lone requester still
// hands priority to the opposite side.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt,
  output logic       gnt_vld,
  output logic       gnt_idx
);

  logic ptr;

  // Grant selection: a single requester always wins, a tie goes to ptr,
  // and nothing is granted while the output cannot accept.
  always_comb begin
    gnt = 2'b00;
    if (en) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = ptr ? 2'b10 : 2'b01;
        default: gnt = 2'b00;
      endcase
    end
    gnt_vld = |gnt;
    gnt_idx = gnt[1];
  end

  // Pointer update: after a grant to input k, priority moves to the other
  // input. Without a grant the pointer holds.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr <= 1'b0;
    end else if (gnt_vld) begin
      ptr <= ~gnt_idx;
    end
  end

endmodule

// File: rtl/butterfly_switch_allocator.sv
// Switch allocator for a 2x2 butterfly router stage.
//
// The allocator watches both FWFT input FIFO heads. It derives each head's
// output port from its dest address and this router's stage level. It then
// round-robin arbitrates per output and issues registered FIFO pops,
// crossbar selects and output valids one cycle after the decision.
//
// Ports:
//   clk              in   clock
//   rst              in   synchronous reset, active-low
//   level            in   [LVL_W-1:0] stage index of this router (static)
//   head0/head1      in   [FLIT_W-1:0] FIFO heads (0 = up, 1 = down)
//   empty0/empty1    in   FIFO empty flags
//   out_rdy0/1       in   downstream of each output can accept
//   rd_en0/1         out  pop strobe per input FIFO
//   sel0/sel1        out  crossbar source per output (0 = in0, 1 = in1)
//   out_vld0/1       out  output carries a valid flit this cycle
//   route_err        out  sticky: an illegal level was seen while requesting
//
// Optional build macro ALLOC_STATS_EN adds gnt_cnt0, gnt_cnt1 and
// conflict_cnt (16-bit saturating counters). Without it those ports and
// counters do not exist and the allocator behaves identically.
//
// Widths come from butterfly_pkg. The parameters exist for visibility, and
// the package helpers assume the package defaults.
module butterfly_switch_allocator #(
  parameter int ADDR_W = butterfly_pkg::ADDR_W,
  parameter int LVL_W  = butterfly_pkg::LVL_W,
  parameter int FLIT_W = butterfly_pkg::FLIT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [LVL_W-1:0]  level,
  input  logic [FLIT_W-1:0] head0,
  input  logic [FLIT_W-1:0] head1,
  input  logic              empty0,
  input  logic              empty1,
  input  logic              out_rdy0,
  input  logic              out_rdy1,
  output logic              rd_en0,
  output logic              rd_en1,
  output logic              sel0,
  output logic              sel1,
  output logic              out_vld0,
  output logic              out_vld1,
  output logic              route_err
`ifdef ALLOC_STATS_EN
  ,
  output logic [15:0]       gnt_cnt0,
  output logic [15:0]       gnt_cnt1,
  output logic [15:0]       conflict_cnt
`endif
);

  import butterfly_pkg::*;

  logic              level_bad;
  logic [ADDR_W-1:0] bit_mask;
  port_e             port0;
  port_e             port1;
  logic              req0;
  logic              req1;
  logic [1:0]        cand_out0;
  logic [1:0]        cand_out1;
  logic [1:0]        gnt_out0;
  logic [1:0]        gnt_out1;
  logic              gnt_vld0;
  logic              gnt_vld1;
  logic              gnt_idx0;
  logic              gnt_idx1;
  logic              unused_head_bits;

  assign unused_head_bits = ^{head0[FLIT_W-1:ADDR_W], head1[FLIT_W-1:ADDR_W]};

  // Route decode and request masking. Stage `level` switches on dest bit
  // ADDR_W-1-level. An out-of-range level produces an all-zero mask, which
  // steers everything to the up port. An input popped last cycle sits out
  // one cycle, so its FIFO can present the next head before it competes again.
  always_comb begin
    level_bad = (int'(level) >= ADDR_W);
    bit_mask  = '0;
    if (!level_bad) begin
      bit_mask = ADDR_W'(1) << (ADDR_W - 1 - int'(level));
    end
    port0 = port_e'(|(get_dest(head0) & bit_mask));
    port1 = port_e'(|(get_dest(head1) & bit_mask));
    req0  = !empty0 && !rd_en0;
    req1  = !empty1 && !rd_en1;
    cand_out0 = {req1 && (port1 == PORT_UP),   req0 && (port0 == PORT_UP)};
    cand_out1 = {req1 && (port1 == PORT_DOWN), req0 && (port0 == PORT_DOWN)};
  end

  rr_arbiter2 u_arb_out0 (
    .clk     (clk),
    .rst     (rst),
    .req     (cand_out0),
    .en      (out_rdy0),
    .gnt     (gnt_out0),
    .gnt_vld (gnt_vld0),
    .gnt_idx (gnt_idx0)
  );

  rr_arbiter2 u_arb_out1 (
    .clk     (clk),
    .rst     (rst),
    .req     (cand_out1),
    .en      (out_rdy1),
    .gnt     (gnt_out1),
    .gnt_vld (gnt_vld1),
    .gnt_idx (gnt_idx1)
  );

  // Registered strobes. Every grant decided this cycle becomes a one-cycle
  // pop, valid and select next cycle. A select only changes on a grant, so
  // an idle output keeps pointing at its last source.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_en0   <= 1'b0;
      rd_en1   <= 1'b0;
      sel0     <= 1'b0;
      sel1     <= 1'b0;
      out_vld0 <= 1'b0;
      out_vld1 <= 1'b0;
    end else begin
      rd_en0   <= gnt_out0[0] | gnt_out1[0];
      rd_en1   <= gnt_out0[1] | gnt_out1[1];
      out_vld0 <= gnt_vld0;
      out_vld1 <= gnt_vld1;
      if (gnt_vld0) begin
        sel0 <= gnt_idx0;
      end
      if (gnt_vld1) begin
        sel1 <= gnt_idx1;
      end
    end
  end

  // Sticky route error. It is flagged only when an illegal level actually
  // affects a pending request, and only reset clears it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      route_err <= 1'b0;
    end else if (level_bad && (req0 || req1)) begin
      route_err <= 1'b1;
    end
  end

`ifdef ALLOC_STATS_EN
  logic conflict_any;

  assign conflict_any = (&cand_out0) | (&cand_out1);

  // Statistics counters. They count grants per output and cycles where both
  // inputs want the same output, whether or not that output was ready.
  // All three counters saturate.
  always_ff @(posedge clk) begin
    if (!rst) begin
      gnt_cnt0     <= '0;
      gnt_cnt1     <= '0;
      conflict_cnt <= '0;
    end else begin
      if (gnt_vld0) begin
        gnt_cnt0 <= sat_inc(gnt_cnt0);
      end
      if (gnt_vld1) begin
        gnt_cnt1 <= sat_inc(gnt_cnt1);
      end
      if (conflict_any) begin
        conflict_cnt <= sat_inc(conflict_cnt);
      end
    end
  end
`endif

endmodule
